// File: rtl/scoreboard.sv
// Seven-segment glyph renderer for one 8x8 score cell: maps (score, x, y) to a
// registered RGB pixel, one cycle after sampling.
module scoreboard #(
  parameter logic [2:0] FG_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score,
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [2:0] dout
);

  // segment vector bit order: {g,f,e,d,c,b,a}
  logic [6:0] seg_en;
  logic [6:0] seg_hit;
  logic       hspan, vtop, vbot, lit;

  always_comb begin
    seg_en = 7'b000_0000;
    case (score)
      4'd0: seg_en = 7'b011_1111;
      4'd1: seg_en = 7'b000_0110;
      4'd2: seg_en = 7'b101_1011;
      4'd3: seg_en = 7'b100_1111;
      4'd4: seg_en = 7'b110_0110;
      4'd5: seg_en = 7'b110_1101;
      4'd6: seg_en = 7'b111_1101;
      4'd7: seg_en = 7'b000_0111;
      4'd8: seg_en = 7'b111_1111;
      4'd9: seg_en = 7'b110_1111;
      default: seg_en = 7'b000_0000;
    endcase
  end

  // Vertical segments share row 3 with the middle bar, so the upper and lower
  // halves overlap at y==3.
  assign hspan = (x >= 3'd1) && (x <= 3'd6);
  assign vtop  = (y <= 3'd3);
  assign vbot  = (y >= 3'd3) && (y <= 3'd6);

  always_comb begin
    seg_hit    = 7'b000_0000;
    seg_hit[0] = (y == 3'd0) && hspan;
    seg_hit[1] = (x == 3'd6) && vtop;
    seg_hit[2] = (x == 3'd6) && vbot;
    seg_hit[3] = (y == 3'd6) && hspan;
    seg_hit[4] = (x == 3'd1) && vbot;
    seg_hit[5] = (x == 3'd1) && vtop;
    seg_hit[6] = (y == 3'd3) && hspan;
  end

  assign lit = |(seg_en & seg_hit);

  always_ff @(posedge clk) begin
    if (rst) dout <= BG_COLOR;
    else     dout <= lit ? FG_COLOR : BG_COLOR;
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: reset, latency, single-pixel cases and full
// cell sweeps against a letter-table segment model.
module tb_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] score;
  logic [2:0] x, y;
  logic [2:0] dout;

  int nvec = 0;
  int nerr = 0;

  string digit_segs [10];

  scoreboard dut (
    .clk  (clk),
    .rst  (rst),
    .score(score),
    .x    (x),
    .y    (y),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after a rising edge; outputs sampled likewise
  task automatic apply(input int s, input int px, input int py);
    score = 4'(s);
    x     = 3'(px);
    y     = 3'(py);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] golden(input int s, input int px, input int py);
    string  sg;
    logic   on;
    byte    ch;
    on = 1'b0;
    if (s > 9) return 3'b000;
    sg = digit_segs[s];
    for (int i = 0; i < sg.len(); i++) begin
      ch = sg[i];
      case (ch)
        "a": if (py == 0 && px >= 1 && px <= 6) on = 1'b1;
        "b": if (px == 6 && py >= 0 && py <= 3) on = 1'b1;
        "c": if (px == 6 && py >= 3 && py <= 6) on = 1'b1;
        "d": if (py == 6 && px >= 1 && px <= 6) on = 1'b1;
        "e": if (px == 1 && py >= 3 && py <= 6) on = 1'b1;
        "f": if (px == 1 && py >= 0 && py <= 3) on = 1'b1;
        "g": if (py == 3 && px >= 1 && px <= 6) on = 1'b1;
        default: ;
      endcase
    end
    return on ? 3'b111 : 3'b000;
  endfunction

  initial begin
    int lit_cnt;
    digit_segs[0] = "abcdef";  digit_segs[1] = "bc";
    digit_segs[2] = "abged";   digit_segs[3] = "abgcd";
    digit_segs[4] = "fgbc";    digit_segs[5] = "afgcd";
    digit_segs[6] = "afgedc";  digit_segs[7] = "abc";
    digit_segs[8] = "abcdefg"; digit_segs[9] = "abcdfg";

    rst = 1'b1; score = 4'd8; x = 3'd3; y = 3'd3;
    @(posedge clk); #1;
    chk("reset", dout, 3'b000);
    @(posedge clk); #1;
    chk("reset_hold", dout, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release", dout, 3'b111);

    // digit 8 sweep; union of all segments is 26 pixels
    lit_cnt = 0;
    for (int py = 0; py < 8; py++)
      for (int px = 0; px < 8; px++) begin
        apply(8, px, py);
        chk($sformatf("d8_x%0d_y%0d", px, py), dout, golden(8, px, py));
        if (px == 0 || px == 7 || py == 7) chk("d8_gap", dout, 3'b000);
        if (dout == 3'b111) lit_cnt++;
      end
    nvec++;
    if (lit_cnt != 26) begin
      nerr++;
      $display("FAIL d8_litcount: got %0d expected 26", lit_cnt);
    end

    apply(0, 3, 3); chk("d0_mid", dout, 3'b000);
    apply(8, 3, 3); chk("d8_mid", dout, 3'b111);
    apply(0, 1, 3); chk("d0_left", dout, 3'b111);

    apply(1, 6, 0); chk("d1_tr", dout, 3'b111);
    apply(1, 6, 6); chk("d1_br", dout, 3'b111);
    apply(1, 1, 0); chk("d1_tl", dout, 3'b000);
    apply(1, 3, 6); chk("d1_bot", dout, 3'b000);

    // score switch: output must hold until the next edge
    apply(6, 1, 5); chk("lat_d6", dout, 3'b111);
    score = 4'd5;
    #2;
    chk("lat_hold", dout, 3'b111);
    @(posedge clk); #1;
    chk("lat_d5", dout, 3'b000);

    // mid-stream reset blanks only while asserted
    score = 4'd8; x = 3'd3; y = 3'd0;
    @(posedge clk); #1;
    chk("mid_pre", dout, 3'b111);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst", dout, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_post", dout, 3'b111);

    for (int s = 10; s < 16; s++)
      for (int py = 0; py < 8; py++)
        for (int px = 0; px < 8; px++) begin
          apply(s, px, py);
          chk($sformatf("inv%0d_x%0d_y%0d", s, px, py), dout, 3'b000);
        end

    for (int s = 0; s < 10; s++)
      for (int py = 0; py < 8; py++)
        for (int px = 0; px < 8; px++) begin
          apply(s, px, py);
          chk($sformatf("d%0d_x%0d_y%0d", s, px, py), dout, golden(s, px, py));
        end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
